// File: rtl/counter_step_sequencer.sv
// counter_step_sequencer
//   Issues INC / DEC / SET step requests to a downstream BCD counter with a
//   Request / Ready handshake and reports completion with the captured
//   counter value.
//
//   Optional feature macro: COUNTER_STEP_SEQUENCER_TIMEOUT_EN
//     defined   -> per-step watchdog; a step that is not acknowledged within
//                  TIMEOUT cycles aborts the command with a one-cycle Error.
//     undefined -> Error is tied 0 and the FSM waits indefinitely.
//
//   Ports
//     Clk, Rst_n       clock, asynchronous active-low reset
//     CmdValid/Ready   command handshake (accepted only in IDLE with Ready=1)
//     CmdOp            00 INC, 01 DEC, 10 SET, 11 reserved (NOP)
//     CmdCount         number of INC/DEC steps (ignored for SET)
//     CmdData          BCD load value for SET
//     Request          one-cycle step strobe to the counter
//     Dec, Set, In     direction, load select and load value to the counter
//     Ready, Out       counter idle/complete flag and counter value
//     Busy             high in every state except IDLE
//     Done, Result     completion pulse and Out captured at completion
//     Error            one-cycle watchdog abort pulse
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   IDLE       | waiting for a command; CmdReady follows Ready
//   ISSUE      | Request high for this single cycle
//   WAIT_BUSY  | waiting for the counter to drop Ready (step taken)
//   WAIT_READY | waiting for the counter to raise Ready (step complete)
//   DONE       | Done high, Result valid; returns to IDLE next cycle
module counter_step_sequencer #(
    parameter int D_NUM   = 3,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 1000
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 CmdValid,
    output logic                 CmdReady,
    input  logic [1:0]           CmdOp,
    input  logic [CNT_W-1:0]     CmdCount,
    input  logic [D_NUM*4-1:0]   CmdData,
    output logic                 Request,
    output logic                 Dec,
    output logic                 Set,
    output logic [D_NUM*4-1:0]   In,
    input  logic                 Ready,
    input  logic [D_NUM*4-1:0]   Out,
    output logic                 Busy,
    output logic                 Done,
    output logic [D_NUM*4-1:0]   Result,
    output logic                 Error
);

    localparam logic [1:0] OP_INC = 2'b00;
    localparam logic [1:0] OP_DEC = 2'b01;
    localparam logic [1:0] OP_SET = 2'b10;

    if (D_NUM < 1 || CNT_W < 1 || TIMEOUT < 1) begin : g_param_check
        $error("counter_step_sequencer: D_NUM, CNT_W and TIMEOUT must be >= 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_READY,
        DONE
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     remaining;
    logic [CNT_W-1:0]     remaining_dec;
    logic                 request_q;
    logic                 dec_q;
    logic                 set_q;
    logic [D_NUM*4-1:0]   in_q;
    logic                 done_q;
    logic [D_NUM*4-1:0]   result_q;
    logic                 accept;

    assign CmdReady = (state == IDLE) && Ready;
    assign accept   = CmdValid && CmdReady;
    assign Busy     = (state != IDLE);

    // Saturating decrement keeps remaining from underflowing.
    assign remaining_dec = (remaining != '0) ? remaining - 1'b1 : '0;

`ifdef COUNTER_STEP_SEQUENCER_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    logic [TMR_W-1:0] wd_cnt;
    logic             wd_expired;
    logic             error_q;

    // wd_cnt is 0 in the first WAIT_BUSY cycle, so the abort lands exactly
    // TIMEOUT cycles after WAIT_BUSY entry.
    assign wd_expired = (wd_cnt == TMR_W'(TIMEOUT - 1));
    assign Error      = error_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wd_cnt <= '0;
        end else if (state == ISSUE) begin
            wd_cnt <= '0;
        end else if (state == WAIT_BUSY || state == WAIT_READY) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign Error = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            request_q <= 1'b0;
            dec_q     <= 1'b0;
            set_q     <= 1'b0;
            in_q      <= '0;
            done_q    <= 1'b0;
            result_q  <= '0;
`ifdef COUNTER_STEP_SEQUENCER_TIMEOUT_EN
            error_q   <= 1'b0;
`endif
        end else begin
            request_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef COUNTER_STEP_SEQUENCER_TIMEOUT_EN
            error_q   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (accept) begin
                        dec_q <= (CmdOp == OP_DEC);
                        set_q <= (CmdOp == OP_SET);
                        in_q  <= CmdData;
                        if (CmdOp == OP_SET) begin
                            remaining <= CNT_W'(1);
                            request_q <= 1'b1;
                            state     <= ISSUE;
                        end else if ((CmdOp == OP_INC || CmdOp == OP_DEC) &&
                                     CmdCount != '0) begin
                            remaining <= CmdCount;
                            request_q <= 1'b1;
                            state     <= ISSUE;
                        end else begin
                            // Zero-step or reserved op: complete with no Request.
                            remaining <= '0;
                            done_q    <= 1'b1;
                            result_q  <= Out;
                            state     <= DONE;
                        end
                    end
                end

                ISSUE: begin
                    state <= WAIT_BUSY;
                end

                WAIT_BUSY: begin
`ifdef COUNTER_STEP_SEQUENCER_TIMEOUT_EN
                    if (wd_expired) begin
                        remaining <= '0;
                        error_q   <= 1'b1;
                        state     <= IDLE;
                    end else
`endif
                    if (!Ready) begin
                        state <= WAIT_READY;
                    end
                end

                WAIT_READY: begin
`ifdef COUNTER_STEP_SEQUENCER_TIMEOUT_EN
                    if (wd_expired) begin
                        remaining <= '0;
                        error_q   <= 1'b1;
                        state     <= IDLE;
                    end else
`endif
                    if (Ready) begin
                        remaining <= remaining_dec;
                        if (remaining_dec == '0) begin
                            // Result and Done are presented together in DONE.
                            done_q   <= 1'b1;
                            result_q <= Out;
                            state    <= DONE;
                        end else begin
                            request_q <= 1'b1;
                            state     <= ISSUE;
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign Request = request_q;
    assign Dec     = dec_q;
    assign Set     = set_q;
    assign In      = in_q;
    assign Done    = done_q;
    assign Result  = result_q;

endmodule

// File: tb/tb_counter_step_sequencer.sv
// Testbench for counter_step_sequencer with a behavioural 3-digit BCD
// counter (wraps 255 -> 000 on INC and 000 -> 255 on DEC).
module tb_counter_step_sequencer;

    localparam int D_NUM      = 3;
    localparam int CNT_W      = 8;
    localparam int TB_TIMEOUT = 40;

    logic              Clk = 1'b0;
    logic              Rst_n = 1'b0;
    logic              CmdValid = 1'b0;
    logic              CmdReady;
    logic [1:0]        CmdOp = 2'b00;
    logic [CNT_W-1:0]  CmdCount = '0;
    logic [11:0]       CmdData = '0;
    logic              Request;
    logic              Dec;
    logic              Set;
    logic [11:0]       In;
    logic              Ready = 1'b1;
    logic [11:0]       Out = 12'h000;
    logic              Busy;
    logic              Done;
    logic [11:0]       Result;
    logic              Error;

    counter_step_sequencer #(
        .D_NUM  (D_NUM),
        .CNT_W  (CNT_W),
        .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .CmdValid(CmdValid),
        .CmdReady(CmdReady),
        .CmdOp   (CmdOp),
        .CmdCount(CmdCount),
        .CmdData (CmdData),
        .Request (Request),
        .Dec     (Dec),
        .Set     (Set),
        .In      (In),
        .Ready   (Ready),
        .Out     (Out),
        .Busy    (Busy),
        .Done    (Done),
        .Result  (Result),
        .Error   (Error)
    );

    always #5 Clk = ~Clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // ---------------- behavioural counter ----------------
    function automatic logic [11:0] to_bcd(input int v);
        logic [3:0] h, t, u;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        u = 4'(v % 10);
        return {h, t, u};
    endfunction

    function automatic int from_bcd(input logic [11:0] b);
        return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic int step_val(input int v, input logic d, input logic s, input logic [11:0] din);
        if (s) return from_bcd(din);
        if (d) return (v == 0) ? 255 : v - 1;
        return (v == 255) ? 0 : v + 1;
    endfunction

    int          val_m = 0;
    int          pend  = 0;
    bit          stall = 1'b0;
    logic        m_dec = 1'b0;
    logic        m_set = 1'b0;
    logic [11:0] m_in  = '0;

    always @(posedge Clk) begin
        if (pend == 0 && Ready && Request) begin
            Ready <= 1'b0;
            pend  <= 3;
            m_dec <= Dec;
            m_set <= Set;
            m_in  <= In;
        end else if (pend > 1) begin
            pend <= pend - 1;
        end else if (pend == 1 && !stall) begin
            val_m <= step_val(val_m, m_dec, m_set, m_in);
            Out   <= to_bcd(step_val(val_m, m_dec, m_set, m_in));
            Ready <= 1'b1;
            pend  <= 0;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [11:0] res;
        int          reqs;
        logic        dec;
        logic        set;
        logic [11:0] din;
    } sb_t;

    sb_t sb_q[$];
    sb_t mon_e;
    int  req_cnt = 0;

    always @(negedge Clk) begin
        if (!Rst_n) begin
            req_cnt = 0;
        end else begin
            if (Request) begin
                req_cnt++;
                if (sb_q.size() > 0) begin
                    chk("req_dec", Dec, sb_q[0].dec);
                    chk("req_set", Set, sb_q[0].set);
                    if (sb_q[0].set) chk("req_in", In, sb_q[0].din);
                end
            end
            if (Done) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("result", Result, mon_e.res);
                    chk("req_count", req_cnt, mon_e.reqs);
                end
                req_cnt = 0;
            end
            if (Error) req_cnt = 0;
        end
    end

    // ---------------- driver ----------------
    task automatic drive_accept(input logic [1:0] op, input logic [7:0] cnt, input logic [11:0] data);
        int guard;
        @(negedge Clk);
        CmdValid = 1'b1;
        CmdOp    = op;
        CmdCount = cnt;
        CmdData  = data;
        guard    = 0;
        while (!CmdReady && guard < 200) begin
            @(negedge Clk);
            guard++;
        end
        if (guard >= 200) chk("accept_timeout", 0, 1);
        @(posedge Clk);
        #1 CmdValid = 1'b0;
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] cnt, input logic [11:0] data,
                        input logic [11:0] exp_res, input int exp_reqs, output int lat);
        sb_t e;
        int  n;
        e.res  = exp_res;
        e.reqs = exp_reqs;
        e.dec  = (op == 2'b01);
        e.set  = (op == 2'b10);
        e.din  = data;
        sb_q.push_back(e);
        drive_accept(op, cnt, data);
        lat = 0;
        n   = 0;
        do begin
            @(negedge Clk);
            n++;
            if (n == 1) chk("cmdready_busy", CmdReady, 0);
            if (Done && lat == 0) lat = n;
        end while (Busy && n < 500);
        if (n >= 500) chk("done_timeout", 0, 1);
    endtask

    int lat;

    initial begin
        // reset state
        #12;
        chk("rst_request", Request, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_error", Error, 0);
        chk("rst_result", Result, 12'h000);
        chk("rst_dec", Dec, 0);
        chk("rst_set", Set, 0);
        chk("rst_in", In, 12'h000);
        @(negedge Clk);
        Rst_n = 1'b1;

        send(2'b00, 8'd5, 12'h000, 12'h005, 5, lat);
        send(2'b01, 8'd5, 12'h000, 12'h000, 5, lat);
        send(2'b10, 8'd7, 12'h123, 12'h123, 1, lat);
        send(2'b00, 8'd0, 12'h000, 12'h123, 0, lat);
        chk("zero_count_latency", lat, 1);
        send(2'b11, 8'd4, 12'h999, 12'h123, 0, lat);
        chk("nop_latency", lat, 1);
        send(2'b10, 8'd0, 12'h254, 12'h254, 1, lat);
        send(2'b00, 8'd3, 12'h000, 12'h001, 3, lat);
        send(2'b01, 8'd2, 12'h000, 12'h255, 2, lat);

        // asynchronous reset in the middle of a multi-step command
        drive_accept(2'b00, 8'd5, 12'h000);
        repeat (3) @(posedge Clk);
        #3 Rst_n = 1'b0;
        #1;
        chk("midrst_request", Request, 0);
        chk("midrst_busy", Busy, 0);
        chk("midrst_result", Result, 12'h000);
        chk("midrst_dec", Dec, 0);
        repeat (8) @(negedge Clk);
        Rst_n = 1'b1;

        send(2'b10, 8'd0, 12'h042, 12'h042, 1, lat);
        send(2'b00, 8'd2, 12'h000, 12'h044, 2, lat);

`ifdef COUNTER_STEP_SEQUENCER_TIMEOUT_EN
        begin
            int n;
            int t_req;
            int t_err;
            stall = 1'b1;
            drive_accept(2'b00, 8'd2, 12'h000);
            n     = 0;
            t_req = -1;
            t_err = -1;
            do begin
                @(negedge Clk);
                n++;
                if (Request && t_req < 0) t_req = n;
                if (Error) t_err = n;
            end while (Busy && n < TB_TIMEOUT + 50);
            // Request cycle, then WAIT_BUSY entry edge, then TIMEOUT cycles.
            chk("err_latency", t_err - t_req, TB_TIMEOUT + 1);
            chk("busy_after_err", Busy, 0);
            chk("result_after_err", Result, 12'h044);
            stall = 1'b0;
            repeat (10) @(negedge Clk);
        end
`endif

        repeat (5) @(negedge Clk);
        chk("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
